mac_col_pipe: RTL and testbench

- Parametrised successor of the systolic-array dot-product column.
- Holds one key vector and streams query vectors through. Each execute beat computes the signed dot product query·key over PR lanes.
- The adder tree is fully pipelined, with log2(PR) levels for any power-of-two PR.
- Adds explicit out_valid and key_valid outputs and a key re-arm command, so the key can be reloaded without a reset.

---
 rtl/mac_pkg.sv | 36 +++
 rtl/mac_col_pipe_add_tree.sv | 53 +++++
 rtl/mac_col_pipe.sv | 183 ++++++++++++++++++
 tb/tb_mac_col_pipe.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the mac_col_pipe dot-product column.
//   inst_t  : 2-bit column command (idle / load / execute / re-arm key)
//   clog2   : constant ceil(log2) used to size the adder tree and counters
//   sext    : sign-extends the low w bits of a value to SEXT_W bits
package mac_pkg;

  typedef enum logic [1:0] {
    INST_IDLE  = 2'b00,
    INST_LOAD  = 2'b01,
    INST_EXEC  = 2'b10,
    INST_REARM = 2'b11
  } inst_t;

  localparam int SEXT_W = 64;

  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

  // Shift the field up to the top bit, then arithmetic-shift it back down.
  function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] v,
                                             input int unsigned       w);
    logic signed [SEXT_W-1:0] t;
    t = $signed(v << (SEXT_W - w));
    return t >>> (SEXT_W - w);
  endfunction

endpackage

// File: rtl/mac_col_pipe_add_tree.sv
// add_tree_pipe: fully registered binary adder tree.
//   Parameters: N (number of inputs, power of two >= 2), IN_W (input width).
//   clk, rst_n : clock and asynchronous active-low reset
//   in_flat    : N signed inputs, element k at [k*IN_W +: IN_W]
//   sum        : signed sum, IN_W+clog2(N) bits, clog2(N) cycles after in_flat
// Level j adds pairs from level j-1, each operand sign-extended by one bit,
// so level j is IN_W+j bits wide and can never overflow.
module add_tree_pipe
  import mac_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int IN_W  = 8,
  localparam int LVLS  = clog2(N),
  localparam int OUT_W = IN_W + LVLS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N*IN_W-1:0] in_flat,
  output logic [OUT_W-1:0]  sum
);

  for (genvar j = 1; j <= LVLS; j++) begin : g_lvl
    localparam int CNT = N >> j;
    localparam int W   = IN_W + j;

    logic [2*CNT*(W-1)-1:0] prev;
    logic [CNT*W-1:0]       sum_d;
    logic [CNT*W-1:0]       sum_q;

    if (j == 1) begin : g_first
      assign prev = in_flat;
    end else begin : g_next
      assign prev = g_lvl[j-1].sum_q;
    end

    always_comb begin
      sum_d = '0;
      for (int k = 0; k < CNT; k++) begin
        sum_d[k*W +: W] =
          {prev[2*k*(W-1) + W-2],     prev[2*k*(W-1) +: W-1]} +
          {prev[(2*k+1)*(W-1) + W-2], prev[(2*k+1)*(W-1) +: W-1]};
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sum_q <= '0;
      else        sum_q <= sum_d;
    end
  end

  assign sum = g_lvl[LVLS].sum_q;

endmodule

// File: rtl/mac_col_pipe.sv
// mac_col_pipe: one column of a systolic dot-product array.
// Holds a key vector and computes signed query.key over PR lanes per execute.
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   i_inst    : command (00 idle, 01 load, 10 execute, 11 re-arm key)
//   q_in      : query/key vector, lane k at [k*BW +: BW], one cycle after i_inst
//   q_out     : registered query, forwarded to the next column
//   o_inst    : i_inst delayed one cycle, forwarded to the next column
//   out       : signed dot product, BW_PSUM bits
//   out_valid : out carries an execute result (no back-pressure: a result is
//               presented for exactly one cycle and the consumer must take it)
//   key_valid : a key has been captured since reset / the last re-arm
// Optional build macro MAC_COL_PIPE_SAT_EN adds an output register stage that
// clamps the result to the signed OUT_BW range (one extra cycle of latency).
module mac_col_pipe
  import mac_pkg::*;
#(
  parameter  int BW      = 4,
  parameter  int PR      = 8,
  parameter  int NUM_COL = 8,
  parameter  int COL_ID  = 0,
  parameter  int OUT_BW  = 2 * BW + clog2(PR),
  localparam int LOG2_PR = clog2(PR),
  localparam int BW_PSUM = 2 * BW + LOG2_PR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         i_inst,
  input  logic [PR*BW-1:0]   q_in,
  output logic [PR*BW-1:0]   q_out,
  output logic [1:0]         o_inst,
  output logic [BW_PSUM-1:0] out,
  output logic               out_valid,
  output logic               key_valid
);

  localparam int PW    = 2 * BW;
  localparam int CNT_W = clog2(NUM_COL + 2);
  // Columns further down the array see the key stream earlier relative to
  // their own loads, so they capture after fewer load beats.
  localparam logic [CNT_W-1:0] CAP_CNT = CNT_W'(NUM_COL + 1 - COL_ID);

  inst_t               inst_d, inst_q;
  logic [PR*BW-1:0]    query_d, query_q;
  logic [PR*BW-1:0]    key_d, key_q;
  logic [CNT_W-1:0]    cnt_d, cnt_q;
  logic                load_ready_d, load_ready_q;
  logic                key_valid_d, key_valid_q;
  logic                exec_d, exec_q;
  logic [PR*PW-1:0]    prod_d, prod_q;
  logic                prod_v_q;
  logic [LOG2_PR-1:0]  tree_v_d, tree_v_q;
  logic [BW_PSUM-1:0]  tree_sum;
  logic [PW-1:0]       qa, kb;

  // Command decode: the instruction registered last cycle qualifies q_in now.
  always_comb begin
    inst_d       = inst_t'(i_inst);
    query_d      = query_q;
    key_d        = key_q;
    cnt_d        = cnt_q;
    load_ready_d = load_ready_q;
    key_valid_d  = key_valid_q;
    exec_d       = 1'b0;
    case (inst_q)
      INST_LOAD: begin
        query_d = q_in;
        if (load_ready_q) begin
          if (cnt_q == CAP_CNT) begin
            key_d        = q_in;
            cnt_d        = '0;
            load_ready_d = 1'b0;
            key_valid_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      INST_EXEC: begin
        query_d = q_in;
        exec_d  = 1'b1;
      end
      INST_REARM: begin
        load_ready_d = 1'b1;
        cnt_d        = '0;
        key_valid_d  = 1'b0;
      end
      default: ;
    endcase
  end

  // Lane products: operands sign-extended to 2*BW, low 2*BW bits are exact.
  always_comb begin
    prod_d = '0;
    qa     = '0;
    kb     = '0;
    for (int k = 0; k < PR; k++) begin
      qa = {{BW{query_q[k*BW + BW-1]}}, query_q[k*BW +: BW]};
      kb = {{BW{key_q[k*BW + BW-1]}},   key_q[k*BW +: BW]};
      prod_d[k*PW +: PW] = qa * kb;
    end
  end

  // Beat tag follows the data one register per tree level.
  always_comb begin
    tree_v_d    = '0;
    tree_v_d[0] = prod_v_q;
    for (int i = 1; i < LOG2_PR; i++) tree_v_d[i] = tree_v_q[i-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst_q       <= INST_IDLE;
      query_q      <= '0;
      key_q        <= '0;
      cnt_q        <= '0;
      load_ready_q <= 1'b1;
      key_valid_q  <= 1'b0;
      exec_q       <= 1'b0;
      prod_q       <= '0;
      prod_v_q     <= 1'b0;
      tree_v_q     <= '0;
    end else begin
      inst_q       <= inst_d;
      query_q      <= query_d;
      key_q        <= key_d;
      cnt_q        <= cnt_d;
      load_ready_q <= load_ready_d;
      key_valid_q  <= key_valid_d;
      exec_q       <= exec_d;
      prod_q       <= prod_d;
      prod_v_q     <= exec_q;
      tree_v_q     <= tree_v_d;
    end
  end

  add_tree_pipe #(
    .N    (PR),
    .IN_W (PW)
  ) u_tree (
    .clk     (clk),
    .rst_n   (reset),
    .in_flat (prod_q),
    .sum     (tree_sum)
  );

`ifdef MAC_COL_PIPE_SAT_EN
  localparam logic signed [BW_PSUM-1:0] SAT_MAX =
    BW_PSUM'(sext(SEXT_W'((64'd1 << (OUT_BW-1)) - 64'd1), OUT_BW));
  localparam logic signed [BW_PSUM-1:0] SAT_MIN =
    BW_PSUM'(sext(SEXT_W'(64'd1 << (OUT_BW-1)), OUT_BW));

  logic [BW_PSUM-1:0] sat_d, sat_q;
  logic               sat_v_q;

  always_comb begin
    sat_d = tree_sum;
    if ($signed(tree_sum) > SAT_MAX)      sat_d = SAT_MAX;
    else if ($signed(tree_sum) < SAT_MIN) sat_d = SAT_MIN;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_q   <= '0;
      sat_v_q <= 1'b0;
    end else begin
      sat_q   <= sat_d;
      sat_v_q <= tree_v_q[LOG2_PR-1];
    end
  end

  assign out       = sat_q;
  assign out_valid = sat_v_q;
`else
  assign out       = tree_sum;
  assign out_valid = tree_v_q[LOG2_PR-1];
`endif

  assign q_out     = query_q;
  assign o_inst    = inst_q;
  assign key_valid = key_valid_q;

endmodule

// File: tb/tb_mac_col_pipe.sv
`timescale 1ns/1ps
module tb_mac_col_pipe;
  import mac_pkg::*;

  localparam int BW      = 4;
  localparam int PR      = 8;
  localparam int NUM_COL = 8;
  localparam int VW      = PR * BW;
  localparam int PW      = 2 * BW + 3;
`ifdef MAC_COL_PIPE_SAT_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 6;
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    i_inst = 2'b00;
  logic [VW-1:0] q_in = '0;
  int            cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [VW-1:0] q_out0, q_out7;
  logic [1:0]    o_inst0, o_inst7;
  logic [PW-1:0] out0, out7;
  logic          out_valid0, out_valid7, key_valid0, key_valid7;

  mac_col_pipe #(.BW(BW), .PR(PR), .NUM_COL(NUM_COL), .COL_ID(0), .OUT_BW(8)) dut0 (
    .clk(clk), .reset(reset), .i_inst(i_inst), .q_in(q_in), .q_out(q_out0),
    .o_inst(o_inst0), .out(out0), .out_valid(out_valid0), .key_valid(key_valid0));

  mac_col_pipe #(.BW(BW), .PR(PR), .NUM_COL(NUM_COL), .COL_ID(7), .OUT_BW(8)) dut7 (
    .clk(clk), .reset(reset), .i_inst(i_inst), .q_in(q_in), .q_out(q_out7),
    .o_inst(o_inst7), .out(out7), .out_valid(out_valid7), .key_valid(key_valid7));

  // ---------------- scoreboard ----------------
  int            total = 0;
  int            bad = 0;
  logic [PW-1:0] exp_q[$];
  int            exp_t_q[$];
  logic [VW-1:0] pend_vec = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat_exp(input int v);
`ifdef MAC_COL_PIPE_SAT_EN
    if (v > 127)  return 127;
    if (v < -128) return -128;
`endif
    return v;
  endfunction

  always @(negedge clk) begin
    if (reset && out_valid0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_valid: got out_valid=1 out=%0d expected no result", $signed(out0));
      end else begin
        logic [PW-1:0] e;
        int            t;
        e = exp_q.pop_front();
        t = exp_t_q.pop_front();
        chk("out", $signed(out0), $signed(e));
        chk("latency", cyc - t, LAT);
      end
    end
  end

  // ---------------- drivers ----------------
  // i_inst for this beat and q_in for the previous beat share a cycle.
  task automatic issue(input logic [1:0] inst, input logic [VW-1:0] vec);
    @(negedge clk);
    i_inst   = inst;
    q_in     = pend_vec;
    pend_vec = vec;
  endtask

  task automatic flush();
    issue(INST_IDLE, '0);
    issue(INST_IDLE, '0);
  endtask

  task automatic exec(input logic [VW-1:0] q, input int expv);
    issue(INST_EXEC, q);
    exp_q.push_back(PW'(sat_exp(expv)));
    exp_t_q.push_back(cyc);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) issue(INST_IDLE, '0);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
      exp_q.delete();
      exp_t_q.delete();
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [VW-1:0] key;
    logic [VW-1:0] query;
    int            exp;
  } vec_t;
  vec_t tbl[4];

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Lane 0 is the lowest nibble. +8 is not a 4-bit signed value, so the
    // ramp query is 0..7: 0+1+..+7 = 28.
    tbl[0] = '{key: 32'h1111_1111, query: 32'h7654_3210, exp: 28};
    tbl[1] = '{key: 32'h8888_8888, query: 32'h8888_8888, exp: 512};   // 8*(-8*-8)
    tbl[2] = '{key: 32'h8888_8888, query: 32'h7777_7777, exp: -448};  // 8*(-8*7)
    // key [1,-1,2,-2,3,-3,7,-8], query [3,3,-4,5,-6,2,1,1]
    tbl[3] = '{key: 32'h87D3_E2F1, query: 32'h112A_5C33, exp: -43};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_out", out0, 0);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_key_valid", key_valid0, 0);
    chk("rst_o_inst", o_inst0, 0);
    chk("rst_q_out", q_out0, 0);
    chk("rst_key_valid7", key_valid7, 0);
    reset = 1'b1;

    // key capture: COL_ID=7 on 3rd load, COL_ID=0 on 10th load
    issue(INST_LOAD, 32'h3333_3333);
    issue(INST_LOAD, 32'h3333_3333);
    flush();
    chk("cap2_kv0", key_valid0, 0);
    chk("cap2_kv7", key_valid7, 0);
    issue(INST_LOAD, 32'h2222_2222);
    issue(INST_IDLE, '0);
    chk("o_inst_load", o_inst0, INST_LOAD);
    issue(INST_IDLE, '0);
    chk("cap3_kv7", key_valid7, 1);
    chk("cap3_kv0", key_valid0, 0);
    chk("q_out_fwd", q_out0, 32'h2222_2222);
    for (int i = 0; i < 6; i++) issue(INST_LOAD, 32'h4444_4444);
    flush();
    chk("cap9_kv0", key_valid0, 0);
    issue(INST_LOAD, 32'h1111_1111);
    flush();
    chk("cap10_kv0", key_valid0, 1);
    // a further load must not replace the key (would give -224 instead of 28)
    issue(INST_LOAD, 32'h8888_8888);
    flush();
    chk("hold_kv0", key_valid0, 1);
    exec(32'h7654_3210, 28);
    drain();

    // table: re-arm, reload key on 10th load, execute
    for (int i = 0; i < 4; i++) begin
      issue(INST_REARM, '0);
      flush();
      chk("rearm_kv0", key_valid0, 0);
      for (int n = 0; n < 9; n++) issue(INST_LOAD, tbl[i].query);
      issue(INST_LOAD, tbl[i].key);
      flush();
      chk("reload_kv0", key_valid0, 1);
      exec(tbl[i].query, tbl[i].exp);
      drain();
    end

    // back-to-back beats against key tbl[3]
    exec(32'h112A_5C33, -43);
    exec(32'h7654_3210, -20);
    exec(32'h1111_1111, -1);
    exec(32'h8888_8888, 8);
    drain();

    // reset in the middle of an execute burst
    exec(32'h7654_3210, -20);
    exec(32'h1111_1111, -1);
    exec(32'h8888_8888, 8);
    @(negedge clk);
    #2 reset = 1'b0;
    exp_q.delete();
    exp_t_q.delete();
    #1;
    chk("mid_rst_out", out0, 0);
    chk("mid_rst_out_valid", out_valid0, 0);
    chk("mid_rst_key_valid", key_valid0, 0);
    chk("mid_rst_o_inst", o_inst0, 0);
    chk("mid_rst_q_out", q_out0, 0);
    i_inst   = INST_IDLE;
    q_in     = '0;
    pend_vec = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) issue(INST_IDLE, '0);
    chk("post_rst_pending", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
